uart_tx_frame: RTL and testbench

- Transmit side of the UART link; pairs with the receiver's oversampled RX path and uses the same prescale value.
- Accepts one parallel byte per handshake and serialises it onto TX_OUT: start bit, 8 data bits LSB-first, optional parity, one stop bit.
- Each bit is held for `prescale` clk cycles.
- Sits between the system-side TX FIFO/controller and the pad.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_frame_if.sv | 26 ++
 rtl/uart_tx_bit_timer.sv | 44 ++++
 rtl/uart_tx_frame.sv | 102 ++++++++++
 tb/tb_uart_tx_frame.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: FSM encoding, parity types, bit levels, prescale floor.
// Latency: n/a (package only).
// Backpressure: n/a; the RX path imports the same definitions.
package uart_pkg;

  // FSM state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  // Shortest bit period the RX oversampler can track
  localparam int MIN_PRESCALE = 4;

  // Bit counter width for an 8-bit payload
  localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/uart_tx_frame_if.sv
// UART TX request/line bundle between the TX controller and the serialiser.
// Latency: n/a (wiring only).
// Backpressure: master watches busy; Data_Valid while busy is dropped by the slave.
// Signals: P_DATA/Data_Valid/PAR_EN/PAR_TYP/prescale (request), TX_OUT/busy (status).
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
);
  logic [DATA_WIDTH-1:0]     P_DATA;
  logic                      Data_Valid;
  logic                      PAR_EN;
  logic                      PAR_TYP;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      TX_OUT;
  logic                      busy;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
    input  TX_OUT, busy
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, prescale,
    output TX_OUT, busy
  );
endinterface

// File: rtl/uart_tx_bit_timer.sv
// Bit timing for the UART TX: edge counter per bit period, bit counter across DATA.
// Latency: bit_done/data_done are combinational from the counter registers.
// Backpressure: none; counts whenever run is high, holds cleared while idle.
// Ports: clk, rst, run, in_data, presc (bit period P) -> bit_done, data_done, bit_cnt.
module uart_tx_bit_timer
  import uart_pkg::*;
#(
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      in_data,
  input  logic [PRESCALE_WIDTH-1:0] presc,
  output logic                      bit_done,
  output logic                      data_done,
  output logic [BIT_CNT_W-1:0]      bit_cnt
);

  logic [PRESCALE_WIDTH-1:0] edge_cnt;

  assign bit_done  = run && (edge_cnt == presc - PRESCALE_WIDTH'(1));
  assign data_done = bit_done && in_data && (bit_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      edge_cnt <= '0;
    end else if (bit_done) begin
      edge_cnt <= '0;
    end else begin
      edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
    end
  end

  // Advances only across data bits; the natural 7->0 wrap leaves it ready for the next frame
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
    end else if (bit_done && in_data) begin
      bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART TX serialiser: start, 8 data bits LSB-first, optional parity, one stop bit.
// Latency: start bit and busy appear on the edge after acceptance; frame is 10*P or 11*P cycles.
// Backpressure: accepts only in IDLE; Data_Valid while busy is ignored, nothing is queued.
// Ports: clk, rst (sync, active high), tx_if (slave: request in, TX_OUT/busy out).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  tx_if
);

  tx_state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_typ_q;
  logic [PRESCALE_WIDTH-1:0] presc_q;
  logic [PRESCALE_WIDTH-1:0] presc_clamped;
  logic                      tx_q, tx_d;
  logic                      busy_q;
  logic                      accept;
  logic                      bit_done, data_done;
  logic [BIT_CNT_W-1:0]      bit_cnt;
  logic [BIT_CNT_W-1:0]      bit_idx_d;
  logic                      par_bit;

  uart_tx_bit_timer #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH)
  ) u_bit_timer (
    .clk       (clk),
    .rst       (rst),
    .run       (state_q != IDLE),
    .in_data   (state_q == DATA),
    .presc     (presc_q),
    .bit_done  (bit_done),
    .data_done (data_done),
    .bit_cnt   (bit_cnt)
  );

  assign presc_clamped = (tx_if.prescale < PRESCALE_WIDTH'(MIN_PRESCALE)) ?
                         PRESCALE_WIDTH'(MIN_PRESCALE) : tx_if.prescale;

  assign par_bit = (^data_q) ^ par_typ_q;

  // TX_OUT is registered, so the mux looks at the bit index the timer will hold next cycle
  assign bit_idx_d = bit_cnt + BIT_CNT_W'((state_q == DATA) && bit_done);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    tx_d    = STOP_BIT;
    case (state_q)
      IDLE: begin
        if (tx_if.Data_Valid) begin
          state_d = START;
          accept  = 1'b1;
        end
      end
      START:   if (bit_done)  state_d = DATA;
      DATA:    if (data_done) state_d = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_done)  state_d = STOP;
      STOP:    if (bit_done)  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = START_BIT;
      DATA:    tx_d = data_q[bit_idx_d];
      PARITY:  tx_d = par_bit;
      default: tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      presc_q   <= '0;
      tx_q      <= STOP_BIT;
      busy_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != IDLE);
      if (accept) begin
        data_q    <= tx_if.P_DATA;
        par_en_q  <= tx_if.PAR_EN;
        par_typ_q <= tx_if.PAR_TYP;
        presc_q   <= presc_clamped;
      end
    end
  end

  assign tx_if.TX_OUT = tx_q;
  assign tx_if.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: table of frames plus hand sequences for back-to-back and mid-frame reset.
// A negedge monitor pops expected frames from a queue and checks the line cycle by cycle.
// Timing: inputs driven #1 after posedge, outputs sampled on negedge.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_tx_frame_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) u_if();

  uart_tx_frame #(.DATA_WIDTH(8), .PRESCALE_WIDTH(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (u_if)
  );

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       par;   // expected parity bit on the line
    int         p;     // expected bit period after clamping
    bit         gap1;  // frame must start after exactly one idle cycle
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       pen;
    logic       typ;
    logic [4:0] presc;
    int         exp_p;
    logic       exp_par;
  } vec_t;

  exp_t exp_q[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   in_frame = 1'b0;
  int   idle_cnt = 0;
  int   k = 0;
  logic [7:0] rx_data;
  logic       rx_par;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: frame checker plus a mid-bit sampling loopback receiver
  always @(negedge clk) begin
    int nb, len, b;
    logic [10:0] fbits;
    if (!mon_en || rst) begin
      in_frame = 1'b0;
      idle_cnt = 0;
    end else begin
      if (!in_frame) begin
        if (u_if.busy) begin
          chk("frame_expected", (exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            k        = 0;
            rx_data  = '0;
            rx_par   = 1'b0;
            if (cur.gap1) chk("b2b_gap", idle_cnt, 1);
          end
        end else begin
          idle_cnt++;
        end
      end
      if (in_frame) begin
        nb    = cur.pen ? 11 : 10;
        len   = nb * cur.p;
        fbits = {1'b1, (cur.pen ? cur.par : 1'b1), cur.data, 1'b0};
        if (k < len) begin
          b = k / cur.p;
          chk("frame_bit", {u_if.busy, u_if.TX_OUT}, {1'b1, fbits[b]});
          if ((k % cur.p) == (cur.p / 2)) begin
            if (b >= 1 && b <= 8) rx_data[b-1] = u_if.TX_OUT;
            if (b == 9) rx_par = u_if.TX_OUT;
          end
          k++;
        end else begin
          chk("frame_end", {u_if.busy, u_if.TX_OUT}, 2'b01);
          chk("rx_data", rx_data, cur.data);
          if (cur.pen) chk("rx_parity", rx_par, cur.par);
          in_frame = 1'b0;
          idle_cnt = 1;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((u_if.busy || in_frame) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: busy=%0b in_frame=%0b required idle within 2000 cycles", u_if.busy, in_frame);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic typ,
                      input logic [4:0] pres, input int exp_p, input logic exp_par);
    exp_t e;
    wait_idle();
    u_if.P_DATA = d; u_if.PAR_EN = pen; u_if.PAR_TYP = typ;
    u_if.prescale = pres; u_if.Data_Valid = 1'b1;
    e.data = d; e.pen = pen; e.par = exp_par; e.p = exp_p; e.gap1 = 1'b0;
    exp_q.push_back(e);
    @(posedge clk); #1;
    // Scramble everything mid-frame; the latched copy must be used
    u_if.Data_Valid = 1'b0;
    u_if.P_DATA = ~d; u_if.PAR_EN = ~pen; u_if.PAR_TYP = ~typ;
    u_if.prescale = 5'($urandom_range(0, 31));
    wait_idle();
  endtask

  vec_t vecs[7];

  initial begin
    u_if.P_DATA = '0; u_if.Data_Valid = 1'b0; u_if.PAR_EN = 1'b0;
    u_if.PAR_TYP = 1'b0; u_if.prescale = 5'd8;

    vecs[0] = '{data:8'hA5, pen:1'b0, typ:1'b0, presc:5'd8,  exp_p:8,  exp_par:1'b0};
    vecs[1] = '{data:8'h03, pen:1'b1, typ:1'b0, presc:5'd16, exp_p:16, exp_par:1'b0};
    vecs[2] = '{data:8'h03, pen:1'b1, typ:1'b1, presc:5'd16, exp_p:16, exp_par:1'b1};
    vecs[3] = '{data:8'hFF, pen:1'b1, typ:1'b1, presc:5'd2,  exp_p:4,  exp_par:1'b1};
    vecs[4] = '{data:8'hFF, pen:1'b1, typ:1'b1, presc:5'd31, exp_p:31, exp_par:1'b1};
    vecs[5] = '{data:8'h3C, pen:1'b1, typ:1'b0, presc:5'd0,  exp_p:4,  exp_par:1'b0};
    vecs[6] = '{data:8'h01, pen:1'b1, typ:1'b0, presc:5'd4,  exp_p:4,  exp_par:1'b1};

    // Reset held three cycles, then idle with no request
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("reset_idle", {u_if.busy, u_if.TX_OUT}, 2'b01);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("post_reset_idle", {u_if.busy, u_if.TX_OUT}, 2'b01);
    end
    mon_en = 1'b1;

    for (int i = 0; i < 7; i++)
      send(vecs[i].data, vecs[i].pen, vecs[i].typ, vecs[i].presc, vecs[i].exp_p, vecs[i].exp_par);

    // Back-to-back: Data_Valid held high, inputs changing every cycle.
    // P=4, no parity -> 40-cycle frames, so acceptances land on cycles 0, 41 and 82.
    wait_idle();
    for (int c = 0; c <= 82; c++) begin
      u_if.Data_Valid = 1'b1;
      if (c == 0 || c == 41 || c == 82) begin
        exp_t e;
        u_if.P_DATA   = (c == 0) ? 8'h11 : (c == 41) ? 8'hC3 : 8'h6E;
        u_if.prescale = 5'd4;
        u_if.PAR_EN   = 1'b0;
        u_if.PAR_TYP  = 1'($urandom_range(0, 1));
        e.data = u_if.P_DATA; e.pen = 1'b0; e.par = 1'b0; e.p = 4; e.gap1 = (c != 0);
        exp_q.push_back(e);
      end else begin
        u_if.P_DATA   = 8'($urandom_range(0, 255));
        u_if.prescale = 5'($urandom_range(0, 31));
        u_if.PAR_EN   = 1'($urandom_range(0, 1));
        u_if.PAR_TYP  = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
    end
    u_if.Data_Valid = 1'b0;
    wait_idle();

    // Reset during DATA bit 3 (P=8: bit 3 spans cycles 33..40 after acceptance)
    mon_en = 1'b0;
    wait_idle();
    u_if.P_DATA = 8'hB4; u_if.PAR_EN = 1'b0; u_if.PAR_TYP = 1'b0;
    u_if.prescale = 5'd8; u_if.Data_Valid = 1'b1;
    @(posedge clk); #1;
    u_if.Data_Valid = 1'b0;
    repeat (34) begin @(posedge clk); #1; end
    chk("pre_reset_bit3", {u_if.busy, u_if.TX_OUT}, 2'b10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("reset_abort", {u_if.busy, u_if.TX_OUT}, 2'b01);
    rst = 1'b0;
    mon_en = 1'b1;
    send(8'hB4, 1'b1, 1'b1, 5'd8, 8, 1'b1);

    wait_idle();
    chk("queue_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
